// File: rtl/bcd_countdown.sv
// MM:SS BCD countdown timer with load/start/stop control and a one-cycle done pulse.
// Asynchronous active-low reset; all outputs are registered.
module bcd_countdown #(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [3:0] SEC_TMAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MIN_TMAX = 4'(MIN_TENS_MAX);

  state_t     state_reg, state_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] sec_reg, sec_next;
  logic       running_reg;
  logic       done_reg, done_next;
  logic [7:0] dec_min, dec_sec;
  logic       count_zero;

  // An over-range tens digit clamps the whole field to its largest legal value
  // (e.g. A5 -> 99); otherwise only an over-range ones digit is clamped to 9.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [3:0] tmax);
    logic [7:0] r;
    r = v;
    if (v[7:4] > tmax)
      r = {tmax, 4'd9};
    else if (v[3:0] > 4'd9)
      r = {v[7:4], 4'd9};
    return r;
  endfunction

  assign count_zero = (min_reg == 8'h00) && (sec_reg == 8'h00);

  // Borrow chain: sec ones -> sec tens -> min ones -> min tens.
  always_comb begin
    dec_sec = sec_reg;
    dec_min = min_reg;
    if (sec_reg[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_reg[3:0] - 4'd1;
    end else begin
      dec_sec[3:0] = 4'd9;
      if (sec_reg[7:4] != 4'd0) begin
        dec_sec[7:4] = sec_reg[7:4] - 4'd1;
      end else begin
        dec_sec[7:4] = SEC_TMAX;
        if (min_reg[3:0] != 4'd0) begin
          dec_min[3:0] = min_reg[3:0] - 4'd1;
        end else begin
          dec_min[3:0] = 4'd9;
          dec_min[7:4] = min_reg[7:4] - 4'd1;
        end
      end
    end
  end

  // A cycle with stop or start is consumed by it even when it has no effect,
  // so en is only honoured in a cycle where load, stop and start are all low.
  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    done_next  = 1'b0;
    if (load) begin
      state_next = IDLE;
      min_next   = clamp_bcd(min_in, MIN_TMAX);
      sec_next   = clamp_bcd(sec_in, SEC_TMAX);
    end else if (stop) begin
      if (state_reg == RUN)
        state_next = PAUSED;
    end else if (start) begin
      if ((state_reg == IDLE || state_reg == PAUSED) && !count_zero)
        state_next = RUN;
    end else if (en && state_reg == RUN) begin
      min_next = dec_min;
      sec_next = dec_sec;
      if (dec_min == 8'h00 && dec_sec == 8'h00) begin
        state_next = DONE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      min_reg     <= 8'h00;
      sec_reg     <= 8'h00;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      sec_reg     <= sec_next;
      running_reg <= (state_next == RUN);
      done_reg    <= done_next;
    end
  end

  assign min     = min_reg;
  assign sec     = sec_reg;
  assign running = running_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_bcd_countdown.sv
// Randomized self-checking bench for bcd_countdown against a seconds-count reference model.
// Directed scenarios for the documented cases, then a long randomized run with async resets.
module tb_bcd_countdown;

  localparam int SEC_PER_MIN = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] min_in = 8'h00, sec_in = 8'h00;
  logic [7:0] min_val, sec_val;
  logic       running, done;

  bcd_countdown dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .start(start), .stop(stop),
    .min_in(min_in), .sec_in(sec_in), .min(min_val), .sec(sec_val),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: total remaining seconds plus a mode word.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int   m_total = 0;
  int   m_mode  = M_IDLE;
  logic m_done  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int clamp_val(input int v, input int tens_max);
    int tens, ones;
    tens = v / 16;
    ones = v % 16;
    if (tens > tens_max) return tens_max * 10 + 9;
    return tens * 10 + ((ones > 9) ? 9 : ones);
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (load) begin
      m_total = clamp_val(int'(min_in), 9) * SEC_PER_MIN + clamp_val(int'(sec_in), 5);
      m_mode  = M_IDLE;
    end else if (stop) begin
      if (m_mode == M_RUN) m_mode = M_PAUSED;
    end else if (start) begin
      if ((m_mode == M_IDLE || m_mode == M_PAUSED) && m_total > 0) m_mode = M_RUN;
    end else if (en && m_mode == M_RUN) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_mode = M_DONE;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_min"}, min_val, to_bcd(m_total / SEC_PER_MIN));
    chk({tag, "_sec"}, sec_val, to_bcd(m_total % SEC_PER_MIN));
    chk({tag, "_run"}, {7'd0, running}, {7'd0, m_mode == M_RUN});
    chk({tag, "_done"}, {7'd0, done}, {7'd0, m_done});
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, check 1ns later.
  task automatic step(input logic l, input logic st, input logic sp, input logic e,
                      input logic [7:0] mi, input logic [7:0] si, input string tag);
    load = l; start = st; stop = sp; en = e; min_in = mi; sec_in = si;
    @(posedge clk);
    model_edge();
    #1;
    $display("%s: ld=%0b st=%0b sp=%0b en=%0b in=%h:%h -> %h:%h run=%0b done=%0b",
             tag, l, st, sp, e, mi, si, min_val, sec_val, running, done);
    check_all(tag);
    @(negedge clk);
  endtask

  // Pulse reset low between clock edges; outputs must clear without waiting for clk.
  task automatic async_reset(input string tag);
    load = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1;
    #2 reset = 1'b0;
    #1;
    m_total = 0; m_mode = M_IDLE; m_done = 1'b0;
    $display("%s: async reset -> %h:%h run=%0b done=%0b", tag, min_val, sec_val, running, done);
    check_all(tag);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #3 reset = 1'b0;
    @(negedge clk);
    chk("rst_min", min_val, 8'h00);
    chk("rst_sec", sec_val, 8'h00);
    chk("rst_run", {7'd0, running}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 01:00 -> one tick -> 00:59 running
    step(1, 0, 0, 0, 8'h01, 8'h00, "ld0100");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start");
    step(0, 0, 0, 1, 8'h00, 8'h00, "tick");
    chk("d031_min", min_val, 8'h00);
    chk("d031_sec", sec_val, 8'h59);

    // 00:02 -> 00:01 -> 00:00 with a single done pulse, then inert
    step(1, 0, 0, 0, 8'h00, 8'h02, "ld0002");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start");
    step(0, 0, 0, 1, 8'h00, 8'h00, "tick1");
    step(0, 0, 0, 1, 8'h00, 8'h00, "tick0");
    chk("d032_done", {7'd0, done}, 8'h01);
    step(0, 0, 0, 1, 8'h00, 8'h00, "post_en");
    chk("d032_done_clr", {7'd0, done}, 8'h00);
    step(0, 1, 0, 0, 8'h00, 8'h00, "post_start");
    step(0, 0, 0, 1, 8'h00, 8'h00, "post_en2");

    // 10:30: stop+en together freezes, resume then tick
    step(1, 0, 0, 0, 8'h10, 8'h30, "ld1030");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start");
    step(0, 0, 1, 1, 8'h00, 8'h00, "stop_en");
    chk("d033_sec", sec_val, 8'h30);
    step(0, 0, 0, 1, 8'h00, 8'h00, "paused_en");
    step(0, 1, 0, 0, 8'h00, 8'h00, "resume");
    step(0, 0, 0, 1, 8'h00, 8'h00, "tick");
    chk("d033_sec2", sec_val, 8'h29);

    // Saturation of out-of-range presets
    step(1, 0, 0, 0, 8'hA5, 8'h7C, "ld_sat");
    chk("d034_min", min_val, 8'h99);
    chk("d034_sec", sec_val, 8'h59);
    step(1, 0, 0, 0, 8'h3C, 8'h4F, "ld_sat2");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start");
    step(0, 0, 0, 1, 8'h00, 8'h00, "tick");

    // 00:00 start is ignored
    step(1, 0, 0, 0, 8'h00, 8'h00, "ld0000");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start0");

    // Asynchronous reset mid-run at 05:17, no done afterwards
    step(1, 0, 0, 0, 8'h05, 8'h17, "ld0517");
    step(0, 1, 0, 0, 8'h00, 8'h00, "start");
    async_reset("rst_mid");
    step(0, 0, 0, 1, 8'h00, 8'h00, "after_rst");
    step(0, 1, 0, 0, 8'h00, 8'h00, "after_rst_start");

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] mi, si;
      mi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 2));
      si = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0)
        async_reset("rnd_rst");
      else
        step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60, mi, si, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
